transport_rx: RTL
=================

Name: transport_rx

Overview:
- Receive-side transport stage; the mirror of the transmit packetizer.
- Consumes the serial byte stream of fixed-size packets delivered by the link layer.
- Parses the header byte and extracts either one 16-bit control word or a run of 16-bit audio samples.
- Delivers control words to the call-control FSM and audio samples to the audio playback path, as single-cycle strobes.

Parameters:
PACKET_BYTES, 16, total bytes per packet including header; legal range 4..64.
CNT_W, 16, width of the good-packet counter.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
byte_in  in  8  received packet byte
byte_valid  in  1  byte_in is valid this cycle; one byte accepted per valid cycle, gaps allowed
sop  in  1  start of packet; qualified by byte_valid; marks the header byte
ctrl_word  out  16  extracted control word; held until the next control packet
ctrl_valid  out  1  one-cycle strobe: new ctrl_word
audio_sample  out  16  extracted audio sample
audio_valid  out  1  one-cycle strobe: new audio_sample
pkt_done  out  1  one-cycle strobe: a well-formed packet fully consumed
pkt_type  out  2  header type of the last completed packet (01 control, 10 audio)
bad_hdr  out  1  one-cycle strobe: header type 00 or 11
short_pkt  out  1  one-cycle strobe: sop arrived before the current packet ended
busy  out  1  high while inside a packet (any state other than IDLE)
pkt_count  out  CNT_W  count of good packets; wraps modulo 2^CNT_W

Behaviour:
- Packet format:
  - Byte 0 is the header; bits [7:6] = type, bits [5:0] ignored.
  - Control packet: bytes 1,2 = control word, MSB first; remaining bytes are padding and ignored.
  - Audio packet: bytes 1..PACKET_BYTES-1 carry samples as big-endian pairs (2k+1, 2k+2).
  - Number of samples = (PACKET_BYTES-1)/2, integer division.
  - An odd trailing byte is ignored. At the default, 7 samples are delivered and byte 15 is dropped.
- Byte index counter:
  - Width = clog2(PACKET_BYTES).
  - Increments only on byte_valid; holds during gaps.
  - Packet ends on acceptance of index PACKET_BYTES-1.
- States: IDLE, CTRL, AUDIO, DROP.
- IDLE:
  - byte_valid&&sop with type 01 -> CTRL; index=1.
  - byte_valid&&sop with type 10 -> AUDIO; index=1.
  - byte_valid&&sop with type 00/11 -> DROP; bad_hdr pulses the next cycle.
  - byte_valid without sop: byte discarded, no strobe.
- CTRL:
  - Byte 1 is latched as high byte; byte 2 as low byte.
  - The cycle after byte 2 is accepted: ctrl_word={hi,lo} and ctrl_valid=1 for exactly one cycle.
- AUDIO:
  - Odd index latches the high byte.
  - The cycle after each even index (<= 2*samples) is accepted: audio_sample updated and audio_valid=1 for one cycle.
  - Back-to-back bytes yield an audio_valid every 2 cycles.
- DROP: consumes bytes to end of packet with no strobes; pkt_count not incremented.
- Packet end (CTRL/AUDIO):
  - The cycle after the last byte: pkt_done=1, pkt_type=type, pkt_count+=1, state -> IDLE.
  - busy falls in the same cycle pkt_done rises.
  - The final sample's audio_valid coincides with pkt_done when the last byte completes a pair.
- DROP end: state -> IDLE; no pkt_done.
- sop while in CTRL/AUDIO/DROP:
  - Current packet aborted; short_pkt pulses the next cycle.
  - Any half-assembled word is discarded; no ctrl_valid/audio_valid for it. Already-emitted samples stand.
  - The sop byte is processed as a new header in that same cycle, with the same transitions as IDLE. So short_pkt and bad_hdr may pulse together.
- sop together with the last byte of a packet: treated as a mid-packet sop; the old packet is aborted (no pkt_done).
- Latency: every strobe is registered, one cycle after the accepting clock edge. No backpressure; downstream must accept every strobe.
- Reset (any time, including mid-packet):
  - Every output goes to 0: ctrl_word, audio_sample, pkt_type, pkt_count, all strobes, busy.
  - State -> IDLE, index=0, latched bytes cleared.
  - A byte presented in the reset cycle is ignored.

Test Plan:
- Control: sop+0x40, 0x12, 0x34, then 13x 0x00 back-to-back -> ctrl_word=0x1234 with ctrl_valid for 1 cycle after byte 2; pkt_done, pkt_type=01, pkt_count=1 one cycle after byte 15.
- Audio with gaps: sop+0x80, then bytes 0x01..0x0F with byte_valid toggling 1/0 -> audio_valid 7 times with samples 0x0102, 0x0304, ... 0x0D0E; byte 0x0F ignored; pkt_done once, pkt_type=10.
- Bad header: sop+0xC0 plus 15 bytes -> bad_hdr 1 cycle; no ctrl/audio strobes; pkt_count unchanged; busy high for 16 accepted bytes. A following valid control packet is decoded normally.
- Abort: audio header, bytes 0xAA, 0xBB, 0xCC, then sop+0x40, 0x56, 0x78 ... -> one sample 0xAABB; 0xCC discarded; short_pkt 1 cycle; then ctrl_word=0x5678; pkt_count increments only for the control packet.
- Reset mid-packet: reset asserted after byte 5 of an audio packet -> all outputs 0 the next cycle. Remaining bytes without sop are discarded, with no strobes, until the next sop.
- Counter wrap: CNT_W=2, five good packets -> pkt_count sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/transport_rx.sv
// Receive-side transport stage: parses fixed-size packets from the link
// byte stream into control-word and audio-sample strobes.
module transport_rx #(
  parameter int PACKET_BYTES = 16,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  input  logic             sop,
  output logic [15:0]      ctrl_word,
  output logic             ctrl_valid,
  output logic [15:0]      audio_sample,
  output logic             audio_valid,
  output logic             pkt_done,
  output logic [1:0]       pkt_type,
  output logic             bad_hdr,
  output logic             short_pkt,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_count
);

  localparam int IDX_W    = $clog2(PACKET_BYTES);
  localparam int SAMP_END = 2 * ((PACKET_BYTES - 1) / 2);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(PACKET_BYTES - 1);
  localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] TWO  = IDX_W'(2);

  typedef enum logic [1:0] {
    IDLE,
    CTRL,
    AUDIO,
    DROP
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       hi_q, hi_d;
  logic [15:0]      ctrl_word_q, ctrl_word_d;
  logic             ctrl_valid_q, ctrl_valid_d;
  logic [15:0]      audio_sample_q, audio_sample_d;
  logic             audio_valid_q, audio_valid_d;
  logic             pkt_done_q, pkt_done_d;
  logic [1:0]       pkt_type_q, pkt_type_d;
  logic             bad_hdr_q, bad_hdr_d;
  logic             short_pkt_q, short_pkt_d;
  logic [CNT_W-1:0] pkt_count_q, pkt_count_d;

  logic hdr_ctrl;
  logic hdr_audio;

  assign hdr_ctrl  = (byte_in[7:6] == 2'b01);
  assign hdr_audio = (byte_in[7:6] == 2'b10);

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    hi_d           = hi_q;
    ctrl_word_d    = ctrl_word_q;
    ctrl_valid_d   = 1'b0;
    audio_sample_d = audio_sample_q;
    audio_valid_d  = 1'b0;
    pkt_done_d     = 1'b0;
    pkt_type_d     = pkt_type_q;
    bad_hdr_d      = 1'b0;
    short_pkt_d    = 1'b0;
    pkt_count_d    = pkt_count_q;

    if (byte_valid) begin
      if (sop) begin
        // A header always restarts parsing, aborting any open packet
        short_pkt_d = (state_q != IDLE);
        idx_d       = ONE;
        hi_d        = '0;
        unique case (1'b1)
          hdr_ctrl:  state_d = CTRL;
          hdr_audio: state_d = AUDIO;
          default: begin
            state_d   = DROP;
            bad_hdr_d = 1'b1;
          end
        endcase
      end else begin
        unique case (state_q)
          CTRL: begin
            if (idx_q == ONE) begin
              hi_d = byte_in;
            end
            if (idx_q == TWO) begin
              ctrl_word_d  = {hi_q, byte_in};
              ctrl_valid_d = 1'b1;
            end
          end
          AUDIO: begin
            if (idx_q[0]) begin
              hi_d = byte_in;
            end else if (int'(idx_q) <= SAMP_END) begin
              audio_sample_d = {hi_q, byte_in};
              audio_valid_d  = 1'b1;
            end
          end
          default: ;
        endcase

        if (state_q != IDLE) begin
          if (idx_q == LAST) begin
            state_d = IDLE;
            idx_d   = '0;
            if (state_q != DROP) begin
              pkt_done_d  = 1'b1;
              pkt_type_d  = (state_q == CTRL) ? 2'b01 : 2'b10;
              pkt_count_d = pkt_count_q + 1'b1;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      hi_q           <= '0;
      ctrl_word_q    <= '0;
      ctrl_valid_q   <= 1'b0;
      audio_sample_q <= '0;
      audio_valid_q  <= 1'b0;
      pkt_done_q     <= 1'b0;
      pkt_type_q     <= '0;
      bad_hdr_q      <= 1'b0;
      short_pkt_q    <= 1'b0;
      pkt_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      hi_q           <= hi_d;
      ctrl_word_q    <= ctrl_word_d;
      ctrl_valid_q   <= ctrl_valid_d;
      audio_sample_q <= audio_sample_d;
      audio_valid_q  <= audio_valid_d;
      pkt_done_q     <= pkt_done_d;
      pkt_type_q     <= pkt_type_d;
      bad_hdr_q      <= bad_hdr_d;
      short_pkt_q    <= short_pkt_d;
      pkt_count_q    <= pkt_count_d;
    end
  end

  assign ctrl_word    = ctrl_word_q;
  assign ctrl_valid   = ctrl_valid_q;
  assign audio_sample = audio_sample_q;
  assign audio_valid  = audio_valid_q;
  assign pkt_done     = pkt_done_q;
  assign pkt_type     = pkt_type_q;
  assign bad_hdr      = bad_hdr_q;
  assign short_pkt    = short_pkt_q;
  assign busy         = (state_q != IDLE);
  assign pkt_count    = pkt_count_q;

endmodule
